// File: rtl/iir_cascade_pkg.sv
// rtl/iir_cascade_pkg.sv - shared types and saturation helper for the biquad cascade scheduler
//
// Purpose: FSM state and tap enumerations, plus the floor-shift-and-clamp helper
//          that turns an accumulator value into an output sample.
// Ports:   none (package)
package iir_cascade_pkg;

  typedef enum logic [1:0] {IDLE, MAC, UPD, OUT} state_t;
  typedef enum logic [2:0] {B0, B1, B2, A1, A2} tap_t;

  // Arithmetic shift (floor), then clamp to the signed out_width range.
  // Works on a 64-bit view so any accumulator width up to 64 fits.
  function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] acc,
                                                   input int scale_factor,
                                                   input int out_width);
    logic signed [63:0] sh;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sh = acc >>> scale_factor;
    hi = (64'sd1 <<< (out_width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_width - 1));
    if (sh > hi) return hi;
    else if (sh < lo) return lo;
    else return sh;
  endfunction

endpackage

// File: rtl/iir_mac_unit.sv
// rtl/iir_mac_unit.sv - shared signed multiply/accumulate for the cascade scheduler
//
// Purpose: one full-precision product per enabled cycle, sign-extended and added
//          to (or subtracted from) the accumulator; clr restarts the sum.
// Ports:   clk, rst_n   clock, async active-low reset
//          en           accumulate this cycle
//          clr          start a new sum with this product
//          sub          subtract the product instead of adding it
//          coef, data   signed operands
//          acc          running accumulator
module iir_mac_unit #(
  parameter int coeff_width = 16,
  parameter int inout_width = 16,
  parameter int acc_width   = 40
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          clr,
  input  logic                          sub,
  input  logic signed [coeff_width-1:0] coef,
  input  logic signed [inout_width-1:0] data,
  output logic signed [acc_width-1:0]   acc
);

  logic signed [coeff_width+inout_width-1:0] prod;
  logic signed [acc_width-1:0]               prod_ext;
  logic signed [acc_width-1:0]               base;

  always_comb begin
    prod     = coef * data;
    prod_ext = acc_width'(prod);
    base     = clr ? '0 : acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc <= '0;
    else if (en) acc <= sub ? (base - prod_ext) : (base + prod_ext);
  end

endmodule

// File: rtl/iir_biquad_cascade_sched.sv
// rtl/iir_biquad_cascade_sched.sv - time-multiplexed DF1 biquad cascade on one MAC
//
// Purpose: accepts one stream sample, runs it through sections 0..num_sections-1
//          (five MAC cycles plus one update cycle each) and emits one result.
// Ports:   clk, rst_n                        clock, async active-low reset
//          s_axis_tdata/tvalid/tready        input sample stream (ready only when idle)
//          m_axis_tdata/tvalid/tready        output sample stream (held until accepted)
//          coeff_wr_en/addr/data/ready       coefficient table write (section*5 + tap)
//          busy                              high whenever a sample is in flight
module iir_biquad_cascade_sched import iir_cascade_pkg::*; #(
  parameter int coeff_width  = 16,
  parameter int inout_width  = 16,
  parameter int scale_factor = 14,
  parameter int num_sections = 4,
  parameter int acc_width    = 40
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic signed [inout_width-1:0]            s_axis_tdata,
  input  logic                                     s_axis_tvalid,
  output logic                                     s_axis_tready,
  output logic signed [inout_width-1:0]            m_axis_tdata,
  output logic                                     m_axis_tvalid,
  input  logic                                     m_axis_tready,
  input  logic                                     coeff_wr_en,
  input  logic [$clog2(5*num_sections)-1:0]        coeff_wr_addr,
  input  logic signed [coeff_width-1:0]            coeff_wr_data,
  output logic                                     coeff_wr_ready,
  output logic                                     busy
);

  localparam int NCOEF = 5 * num_sections;
  localparam int AW    = $clog2(NCOEF);
  localparam int SW    = (num_sections > 1) ? $clog2(num_sections) : 1;

  state_t                        state;
  tap_t                          tap;
  logic [SW-1:0]                 sec;
  logic signed [inout_width-1:0] x_cur;   // input of the section being computed

  logic signed [coeff_width-1:0] coef [NCOEF];
  logic signed [inout_width-1:0] x1 [num_sections];
  logic signed [inout_width-1:0] x2 [num_sections];
  logic signed [inout_width-1:0] y1 [num_sections];
  logic signed [inout_width-1:0] y2 [num_sections];

  logic [AW-1:0]                 cidx;
  logic signed [coeff_width-1:0] mac_coef;
  logic signed [inout_width-1:0] mac_data;
  logic                          mac_en;
  logic                          mac_clr;
  logic                          mac_sub;
  logic signed [acc_width-1:0]   acc;
  logic signed [inout_width-1:0] y_new;

  assign s_axis_tready  = ~busy;
  assign coeff_wr_ready = ~busy;

  // Operand selection for the current (section, tap); feedback taps subtract.
  always_comb begin
    cidx     = AW'(int'(sec) * 5 + int'(tap));
    mac_coef = coef[cidx];
    case (tap)
      B1:      mac_data = x1[sec];
      B2:      mac_data = x2[sec];
      A1:      mac_data = y1[sec];
      A2:      mac_data = y2[sec];
      default: mac_data = x_cur;
    endcase
    mac_en  = (state == MAC);
    mac_clr = (tap == B0);
    mac_sub = (tap == A1) || (tap == A2);
    y_new   = inout_width'(sat_trunc(64'(acc), scale_factor, inout_width));
  end

  iir_mac_unit #(
    .coeff_width(coeff_width),
    .inout_width(inout_width),
    .acc_width  (acc_width)
  ) u_mac (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (mac_en),
    .clr  (mac_clr),
    .sub  (mac_sub),
    .coef (mac_coef),
    .data (mac_data),
    .acc  (acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      tap           <= B0;
      sec           <= '0;
      x_cur         <= '0;
      busy          <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      // Passthrough: every section starts as b0 = 1.0, all other taps 0.
      for (int i = 0; i < NCOEF; i++)
        coef[i] <= (i % 5 == 0) ? coeff_width'(2**scale_factor) : '0;
      for (int i = 0; i < num_sections; i++) begin
        x1[i] <= '0;
        x2[i] <= '0;
        y1[i] <= '0;
        y2[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (coeff_wr_en && int'(coeff_wr_addr) < NCOEF)
            coef[coeff_wr_addr] <= coeff_wr_data;
          if (s_axis_tvalid) begin
            x_cur <= s_axis_tdata;
            sec   <= '0;
            tap   <= B0;
            busy  <= 1'b1;
            state <= MAC;
          end
        end
        MAC: begin
          if (tap == A2) begin
            tap   <= B0;
            state <= UPD;
          end else begin
            tap <= tap_t'(tap + 3'd1);
          end
        end
        UPD: begin
          x2[sec] <= x1[sec];
          x1[sec] <= x_cur;
          y2[sec] <= y1[sec];
          y1[sec] <= y_new;
          x_cur   <= y_new;
          if (int'(sec) == num_sections - 1) begin
            m_axis_tdata  <= y_new;
            m_axis_tvalid <= 1'b1;
            state         <= OUT;
          end else begin
            sec   <= sec + 1'b1;
            state <= MAC;
          end
        end
        OUT: begin
          if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_biquad_cascade_sched.sv
// tb/tb_iir_biquad_cascade_sched.sv - self-checking bench for iir_biquad_cascade_sched
module tb_iir_biquad_cascade_sched;

  logic clk;
  initial clk = 1'b0;
  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // u4: four sections, u1: one section
  logic               rst4_n, rst1_n;
  logic signed [15:0] s4_tdata, s1_tdata, m4_tdata, m1_tdata;
  logic               s4_tvalid, s1_tvalid, s4_tready, s1_tready;
  logic               m4_tvalid, m1_tvalid, m4_tready, m1_tready;
  logic               w4_en, w1_en, w4_ready, w1_ready, busy4, busy1;
  logic [4:0]         w4_addr;
  logic [2:0]         w1_addr;
  logic signed [15:0] w4_data, w1_data;

  iir_biquad_cascade_sched #(.coeff_width(16), .inout_width(16), .scale_factor(14),
                             .num_sections(4), .acc_width(40)) u_dut4 (
    .clk(clk), .rst_n(rst4_n),
    .s_axis_tdata(s4_tdata), .s_axis_tvalid(s4_tvalid), .s_axis_tready(s4_tready),
    .m_axis_tdata(m4_tdata), .m_axis_tvalid(m4_tvalid), .m_axis_tready(m4_tready),
    .coeff_wr_en(w4_en), .coeff_wr_addr(w4_addr), .coeff_wr_data(w4_data),
    .coeff_wr_ready(w4_ready), .busy(busy4));

  iir_biquad_cascade_sched #(.coeff_width(16), .inout_width(16), .scale_factor(14),
                             .num_sections(1), .acc_width(40)) u_dut1 (
    .clk(clk), .rst_n(rst1_n),
    .s_axis_tdata(s1_tdata), .s_axis_tvalid(s1_tvalid), .s_axis_tready(s1_tready),
    .m_axis_tdata(m1_tdata), .m_axis_tvalid(m1_tvalid), .m_axis_tready(m1_tready),
    .coeff_wr_en(w1_en), .coeff_wr_addr(w1_addr), .coeff_wr_data(w1_data),
    .coeff_wr_ready(w1_ready), .busy(busy1));

  int vecs = 0;
  int miss = 0;

  function automatic void chk(string name, longint act, longint exp);
    vecs++;
    if (act != exp) begin
      miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // Reference model: cascade of direct-form-I biquads, floor shift, clamp.
  longint mc  [2][20];
  longint mx1 [2][4];
  longint mx2 [2][4];
  longint my1 [2][4];
  longint my2 [2][4];
  int     nsec [2] = '{4, 1};
  int     exp0_q[$];
  int     exp1_q[$];

  function automatic void model_reset(int d);
    for (int s = 0; s < 4; s++) begin
      mx1[d][s] = 0; mx2[d][s] = 0; my1[d][s] = 0; my2[d][s] = 0;
    end
    for (int i = 0; i < 20; i++) mc[d][i] = (i % 5 == 0) ? 16384 : 0;
  endfunction

  function automatic int model_run(int d, int xin);
    longint x, acc, y;
    x = xin;
    for (int s = 0; s < nsec[d]; s++) begin
      acc = mc[d][s*5] * x + mc[d][s*5+1] * mx1[d][s] + mc[d][s*5+2] * mx2[d][s]
          - mc[d][s*5+3] * my1[d][s] - mc[d][s*5+4] * my2[d][s];
      y = acc >>> 14;
      if (y > 32767) y = 32767;
      if (y < -32768) y = -32768;
      mx2[d][s] = mx1[d][s]; mx1[d][s] = x;
      my2[d][s] = my1[d][s]; my1[d][s] = y;
      x = y;
    end
    return int'(x);
  endfunction

  // Every accepted output is compared against the model's queued value.
  always begin
    @(negedge clk);
    #2;
    if (m4_tvalid && m4_tready) begin
      vecs++;
      if (exp0_q.size() == 0) begin
        miss++;
        $display("FAIL u4_unexpected_out: got %0d, expected no output", m4_tdata);
      end else begin
        vecs--;
        chk("u4_out", m4_tdata, exp0_q.pop_front());
      end
    end
    if (m1_tvalid && m1_tready) begin
      vecs++;
      if (exp1_q.size() == 0) begin
        miss++;
        $display("FAIL u1_unexpected_out: got %0d, expected no output", m1_tdata);
      end else begin
        vecs--;
        chk("u1_out", m1_tdata, exp1_q.pop_front());
      end
    end
  end

  task automatic send(input int d, input int x, output int t, output int e);
    int n;
    n = 0;
    @(negedge clk);
    if (d == 0) begin s4_tdata = 16'(x); s4_tvalid = 1'b1; end
    else        begin s1_tdata = 16'(x); s1_tvalid = 1'b1; end
    while (((d == 0) ? s4_tready : s1_tready) == 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk("send_timeout", n, 0);
    e = model_run(d, x);
    if (d == 0) exp0_q.push_back(e); else exp1_q.push_back(e);
    @(negedge clk);
    t = cyc;
    if (d == 0) s4_tvalid = 1'b0; else s1_tvalid = 1'b0;
  endtask

  task automatic wait_out(input int d, output int tv);
    int n;
    n = 0;
    while (((d == 0) ? m4_tvalid : m1_tvalid) == 1'b0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("out_timeout", n, 0);
    tv = cyc;
  endtask

  task automatic drain(input int d);
    int n;
    n = 0;
    while (((d == 0) ? exp0_q.size() : exp1_q.size()) != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", (d == 0) ? exp0_q.size() : exp1_q.size(), 0);
  endtask

  task automatic wr(input int d, input int addr, input int data, input bit apply);
    @(negedge clk);
    if (d == 0) begin w4_en = 1'b1; w4_addr = 5'(addr); w4_data = 16'(data); chk("wr_ready", w4_ready, 1); end
    else        begin w1_en = 1'b1; w1_addr = 3'(addr); w1_data = 16'(data); chk("wr_ready", w1_ready, 1); end
    @(negedge clk);
    w4_en = 1'b0;
    w1_en = 1'b0;
    if (apply) mc[d][addr] = data;
  endtask

  int t, tv, e, held, bad;
  int c2 [5] = '{2962, 5615, 2962, -9362, 5203};

  initial begin
    rst4_n = 0; rst1_n = 0;
    s4_tdata = 0; s1_tdata = 0; s4_tvalid = 0; s1_tvalid = 0;
    m4_tready = 1; m1_tready = 1;
    w4_en = 0; w1_en = 0; w4_addr = 0; w1_addr = 0; w4_data = 0; w1_data = 0;
    model_reset(0);
    model_reset(1);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_m4_tvalid", m4_tvalid, 0);
    chk("rst_m4_tdata", m4_tdata, 0);
    chk("rst_busy4", busy4, 0);
    chk("rst_m1_tvalid", m1_tvalid, 0);
    rst4_n = 1; rst1_n = 1;
    @(negedge clk);
    chk("rst_s4_tready", s4_tready, 1);
    chk("rst_w4_ready", w4_ready, 1);

    // 1: passthrough defaults, exact latency 6*4
    send(0, 1000, t, e);
    chk("t1_busy", busy4, 1);
    wait_out(0, tv);
    chk("t1_latency", tv - t, 24);
    chk("t1_data", m4_tdata, 1000);
    drain(0);

    // 4: backpressure with a second sample waiting
    m4_tready = 0;
    send(0, 2000, t, e);
    wait_out(0, tv);
    held = m4_tdata;
    chk("t4_data", held, 2000);
    s4_tdata = 3000; s4_tvalid = 1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (!m4_tvalid || m4_tdata != 16'(held) || s4_tready || !busy4) bad++;
    end
    chk("t4_stable", bad, 0);
    m4_tready = 1;
    @(negedge clk);
    chk("t4_ready_after_release", s4_tready, 1);
    chk("t4_tvalid_dropped", m4_tvalid, 0);
    exp0_q.push_back(model_run(0, 3000));
    t = cyc;
    @(negedge clk);
    chk("t4_accepted", busy4, 1);
    s4_tvalid = 0;
    wait_out(0, tv);
    chk("t4_latency2", tv - t, 25);
    drain(0);

    // 5: writes while busy and out of range are ignored; a legal write applies
    send(0, 1200, t, e);
    w4_en = 1; w4_addr = 0; w4_data = 16'sd5000;
    chk("t5_wr_ready_busy", w4_ready, 0);
    @(negedge clk);
    w4_en = 0;
    wait_out(0, tv);
    drain(0);
    wr(0, 20, 5000, 1'b0);
    wr(0, 10, 8192, 1'b1);
    send(0, 1200, t, e);
    chk("t5_model", e, 600);
    wait_out(0, tv);
    drain(0);

    // 6: reset mid-computation
    send(0, 700, t, e);
    repeat (10) @(negedge clk);
    rst4_n = 0;
    #1;
    chk("t6_busy", busy4, 0);
    chk("t6_tvalid", m4_tvalid, 0);
    chk("t6_tdata", m4_tdata, 0);
    exp0_q.delete();
    model_reset(0);
    repeat (2) @(negedge clk);
    rst4_n = 1;
    @(negedge clk);
    send(0, 500, t, e);
    chk("t6_model", e, 500);
    wait_out(0, tv);
    chk("t6_data", m4_tdata, 500);
    drain(0);

    // 2: impulse response of one section
    for (int i = 0; i < 5; i++) wr(1, i, c2[i], 1'b1);
    send(1, 32767, t, e);
    chk("t2_model_first", e, 5923);
    wait_out(1, tv);
    chk("t2_latency", tv - t, 6);
    chk("t2_first", m1_tdata, 5923);
    for (int k = 0; k < 50; k++) begin
      send(1, 0, t, e);
      if (k == 0) chk("t2_model_second", e, 14614);
    end
    drain(1);

    // 3: saturation
    wr(1, 0, 32767, 1'b1);
    for (int i = 1; i < 5; i++) wr(1, i, 0, 1'b1);
    send(1, 30000, t, e);
    chk("t3_model_pos", e, 32767);
    send(1, -30000, t, e);
    chk("t3_model_neg", e, -32768);
    drain(1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
